// File: rtl/multiplier_pipe_param.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_pipe_param
// Brief    : Pipelined WIDTH x WIDTH multiplier, one SLICE-bit partial product
//            per stage, signed/unsigned per operand pair, valid/stall handshake.
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_pipe_param #(
  parameter int WIDTH = 128,
  parameter int SLICE = 32
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iEn,
  input  logic                 iClr,
  input  logic                 iValid,
  input  logic                 iSigned,
  input  logic [WIDTH-1:0]     iData0,
  input  logic [WIDTH-1:0]     iData1,
  output logic                 oValid,
  output logic [2*WIDTH-1:0]   oData
);

  localparam int cSlice  = (SLICE < 1) ? 1 : SLICE;
  localparam int cNSlice = (WIDTH / cSlice < 1) ? 1 : WIDTH / cSlice;

  if (SLICE < 1) begin : g_badSlice
    $error("multiplier_pipe_param: SLICE must be >= 1");
  end else if (WIDTH % SLICE != 0) begin : g_badWidth
    $error("multiplier_pipe_param: WIDTH must be a multiple of SLICE");
  end

  logic [WIDTH-1:0]   wMagA, wMagB;
  logic               rVld  [0:cNSlice];
  logic               rNeg  [0:cNSlice];
  logic [WIDTH-1:0]   rMagA [0:cNSlice-1];
  logic [WIDTH-1:0]   rMagB [0:cNSlice-1];
  logic [2*WIDTH-1:0] rAcc     [1:cNSlice];
  logic [2*WIDTH-1:0] wAccNext [1:cNSlice];

  // The most negative value negates onto itself, which read unsigned is 2^(WIDTH-1).
  assign wMagA = (iSigned && iData0[WIDTH-1]) ? -iData0 : iData0;
  assign wMagB = (iSigned && iData1[WIDTH-1]) ? -iData1 : iData1;

  for (genvar k = 1; k <= cNSlice; k++) begin : g_stage
    logic [cSlice-1:0]         wDigit;
    logic [WIDTH+cSlice-1:0]   wPp;
    logic [2*WIDTH-1:0]        wAccPrev;

    assign wDigit = rMagB[k-1][k*cSlice-1 -: cSlice];
    assign wPp    = (WIDTH+cSlice)'(rMagA[k-1]) * (WIDTH+cSlice)'(wDigit);

    if (k == 1) begin : g_first
      assign wAccPrev = '0;
    end else begin : g_rest
      assign wAccPrev = rAcc[k-1];
    end

    assign wAccNext[k] = wAccPrev + ((2*WIDTH)'(wPp) << ((k-1)*cSlice));
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int k = 0; k <= cNSlice; k++) begin
        rVld[k] <= 1'b0;
        rNeg[k] <= 1'b0;
      end
      for (int k = 0; k < cNSlice; k++) begin
        rMagA[k] <= '0;
        rMagB[k] <= '0;
      end
      for (int k = 1; k <= cNSlice; k++) rAcc[k] <= '0;
      oValid <= 1'b0;
      oData  <= '0;
    end else if (iClr) begin
      for (int k = 0; k <= cNSlice; k++) begin
        rVld[k] <= 1'b0;
        rNeg[k] <= 1'b0;
      end
      for (int k = 0; k < cNSlice; k++) begin
        rMagA[k] <= '0;
        rMagB[k] <= '0;
      end
      for (int k = 1; k <= cNSlice; k++) rAcc[k] <= '0;
      oValid <= 1'b0;
      oData  <= '0;
    end else if (iEn) begin
      rVld[0]  <= iValid;
      rNeg[0]  <= iSigned & (iData0[WIDTH-1] ^ iData1[WIDTH-1]);
      rMagA[0] <= wMagA;
      rMagB[0] <= wMagB;
      for (int k = 1; k <= cNSlice; k++) begin
        rVld[k] <= rVld[k-1];
        rNeg[k] <= rNeg[k-1];
        rAcc[k] <= wAccNext[k];
      end
      for (int k = 1; k < cNSlice; k++) begin
        rMagA[k] <= rMagA[k-1];
        rMagB[k] <= rMagB[k-1];
      end
      // Only the output register is gated by valid; bubbles leave oData untouched.
      oValid <= rVld[cNSlice];
      if (rVld[cNSlice]) begin
        oData <= rNeg[cNSlice] ? -rAcc[cNSlice] : rAcc[cNSlice];
      end
    end
  end

endmodule
`default_nettype wire
